// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
// Optional divide support is controlled by the MULDIV_DIV_EN macro in the
// files that import this package.
package muldiv_pkg;

  // The operand width is also the number of iterations. Only 32 is supported.
  localparam int ITERS = 32;
  localparam int CNT_W = $clog2(ITERS);

  // Shared ALU control codes.
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  // Operation encodings. Bit 1 selects divide and bit 0 selects signed.
  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // 32-bit two's complement negation.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Sign handling for the muldiv sequencer.
// On entry it produces the operand magnitudes. Abs is applied only to signed
// ops, and 0x80000000 passes through as an unsigned 2^31.
// In FIX it produces the sign-corrected HI/LO. When MULDIV_DIV_EN is defined it
// also applies the divide quotient and remainder sign rules.
module muldiv_sign_fix
  import muldiv_pkg::*;
(
  input  logic        is_signed,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] rs_abs,
  output logic [31:0] rt_abs,
`ifdef MULDIV_DIV_EN
  input  logic        is_div,
  input  logic        neg_r,
`endif
  input  logic        neg_q,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] hi_fix,
  output logic [31:0] lo_fix
);

  // Compute the magnitudes of the incoming operands. Unsigned ops pass through unchanged.
  always_comb begin
    rs_abs = (is_signed && rs_val[31]) ? neg32(rs_val) : rs_val;
    rt_abs = (is_signed && rt_val[31]) ? neg32(rt_val) : rt_val;
  end

  // Restore the result signs. A product is negated as a 64-bit value.
  // A quotient and a remainder are negated independently.
  always_comb begin
    hi_fix = hi;
    lo_fix = lo;
`ifdef MULDIV_DIV_EN
    if (is_div) begin
      if (neg_q) lo_fix = neg32(lo);
      if (neg_r) hi_fix = neg32(hi);
    end else if (neg_q) begin
      {hi_fix, lo_fix} = ~{hi, lo} + 64'd1;
    end
`else
    if (neg_q) begin
      {hi_fix, lo_fix} = ~{hi, lo} + 64'd1;
    end
`endif
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer for the EX stage.
// It borrows the shared ALU while busy, runs one shift-add or shift-subtract
// step per cycle, fixes the result signs and then pulses done.
// MULDIV_DIV_EN enables the divide datapath. Without it, divide ops go
// straight from IDLE to DONE and leave HI/LO untouched.
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [3:0]  alu_ctl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ITERS - 1);

  state_e           state;
  state_e           state_nxt;
  logic [CNT_W-1:0] count;
  logic [31:0]      operand;
  logic             neg_q;
  logic             accept_iter;
  logic [31:0]      rs_abs;
  logic [31:0]      rt_abs;
  logic [31:0]      hi_fix;
  logic [31:0]      lo_fix;
  logic [31:0]      mul_b;
  logic             mul_carry;
`ifdef MULDIV_DIV_EN
  logic             is_div;
  logic             neg_r;
  logic             div_acc;
  logic [31:0]      div_t;
`endif

  muldiv_sign_fix u_sign_fix (
    .is_signed (op[0]),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .rs_abs    (rs_abs),
    .rt_abs    (rt_abs),
`ifdef MULDIV_DIV_EN
    .is_div    (is_div),
    .neg_r     (neg_r),
`endif
    .neg_q     (neg_q),
    .hi        (hi),
    .lo        (lo),
    .hi_fix    (hi_fix),
    .lo_fix    (lo_fix)
  );

  assign mul_b     = lo[0] ? operand : '0;
  assign mul_carry = alu_out < alu_a;
`ifdef MULDIV_DIV_EN
  assign div_t       = {hi[30:0], lo[31]};
  assign div_acc     = hi[31] | (div_t >= operand);
  assign accept_iter = start;
`else
  assign accept_iter = start & ~op[1];
`endif

  assign busy  = (state != IDLE);
  assign stall = (start && state == IDLE) || state == ITER || state == FIX;
  assign done  = (state == DONE);

  // Drive the shared ALU. It is only used during ITER and is parked as 0 + 0 otherwise.
  always_comb begin
    alu_ctl = ALU_ADD;
    alu_a   = '0;
    alu_b   = '0;
    if (state == ITER) begin
      alu_a = hi;
      alu_b = mul_b;
`ifdef MULDIV_DIV_EN
      if (is_div) begin
        alu_ctl = ALU_SUB;
        alu_a   = div_t;
        alu_b   = operand;
      end
`endif
    end
  end

  // State register. Reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic. start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef MULDIV_DIV_EN
          state_nxt = ITER;
`else
          state_nxt = op[1] ? DONE : ITER;
`endif
        end
      end
      ITER:    if (count == '0) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load the operands on accept, step once per ITER cycle, and sign-correct in FIX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
      operand <= '0;
      neg_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div  <= 1'b0;
      neg_r   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept_iter) begin
            count <= CNT_INIT;
            hi    <= '0;
            neg_q <= op[0] & (rs_val[31] ^ rt_val[31]);
`ifdef MULDIV_DIV_EN
            is_div <= op[1];
            neg_r  <= op[0] & rs_val[31];
            if (op[1]) begin
              lo      <= rs_abs;
              operand <= rt_abs;
            end else begin
              lo      <= rt_abs;
              operand <= rs_abs;
            end
`else
            lo      <= rt_abs;
            operand <= rs_abs;
`endif
          end
        end
        ITER: begin
          count <= count - CNT_W'(1);
          hi    <= {mul_carry, alu_out[31:1]};
          lo    <= {alu_out[0], lo[31:1]};
`ifdef MULDIV_DIV_EN
          if (is_div) begin
            hi <= div_acc ? alu_out : div_t;
            lo <= {lo[30:0], div_acc};
          end
`endif
        end
        FIX: begin
          hi <= hi_fix;
          lo <= lo_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl. Expected results come from literal
// vectors or from a behavioural model. They are queued when an op is started
// and compared when done pulses.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int LIMIT = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          stall_cycles;
  } exp_t;

  vec_t        vecs[10];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  always #5 clk = ~clk;

  // The shared ALU that the EX stage lends to the sequencer.
  assign alu_out = (alu_ctl == ALU_SUB) ? alu_a - alu_b : alu_a + alu_b;

  muldiv_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .alu_ctl (alu_ctl),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_out (alu_out),
    .busy    (busy),
    .stall   (stall),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  // Reference result as {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    logic [31:0] aa, ab, q, r;
    if (!o[1]) begin
      ea = o[0] ? {{32{a[31]}}, a} : {32'b0, a};
      eb = o[0] ? {{32{b[31]}}, b} : {32'b0, b};
      return ea * eb;
    end
    aa = (o[0] && a[31]) ? -a : a;
    ab = (o[0] && b[31]) ? -b : b;
    if (ab == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = aa;
    end else begin
      q = aa / ab;
      r = aa % ab;
    end
    if (o[0] && (a[31] ^ b[31])) q = -q;
    if (o[0] && a[31]) r = -r;
    return {r, q};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start an op from IDLE and queue its expected result. Returns #1 after the accepting edge.
  task automatic applyStimulus(input string name, input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                               input bit hold);
    exp_t e;
    bit bypass;
    logic [3:0] ctl;
    bypass = !DIV_EN && o[1];
    e.hi = bypass ? model_hi : eh;
    e.lo = bypass ? model_lo : el;
    // A bypassed divide goes from IDLE straight to DONE on the accepting edge.
    e.lat = bypass ? 1 : ITERS + 2;
    e.stall_cycles = bypass ? 1 : ITERS + 2;
    ctl = (o[1] && !bypass) ? ALU_SUB : ALU_ADD;
    sb.push_back(e);
    model_hi = e.hi;
    model_lo = e.lo;
    op = o;
    rs_val = a;
    rt_val = b;
    start = 1'b1;
    #1;
    checkOutput({name, "/start_stall"}, stall, 1);
    @(posedge clk);
    #1;
    checkOutput({name, "/alu_ctl"}, alu_ctl, ctl);
    if (!hold) start = 1'b0;
  endtask

  // Wait for done, then check the latency, stall count and result against the scoreboard.
  task automatic waitDone(input string name, input int lat0, input int st0);
    exp_t e;
    int lat, st;
    lat = lat0;
    st = st0;
    while (!done && lat < LIMIT) begin
      if (stall) st++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s/timeout: no done after %0d cycles", name, lat);
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s/scoreboard: done with nothing expected", name);
    end else begin
      e = sb.pop_front();
      checkOutput({name, "/latency"}, lat, e.lat);
      checkOutput({name, "/stall_cycles"}, st, e.stall_cycles);
      checkOutput({name, "/done_busy_stall"}, {busy, stall}, 2'b10);
      checkOutput({name, "/hi"}, hi, e.hi);
      checkOutput({name, "/lo"}, lo, e.lo);
    end
    @(posedge clk);
    #1;
    checkOutput({name, "/after_done"}, {done, busy}, 2'b00);
  endtask

  initial begin
    int lat, st, extra;
    logic [63:0] r;
    logic [1:0] ro;
    logic [31:0] ra, rb;

    vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{OP_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
    vecs[4] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[5] = '{OP_MULTU, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F};
    vecs[6] = '{OP_DIVU,  32'h0000_000F, 32'h0000_0004, 32'h0000_0003, 32'h0000_0003};
    vecs[7] = '{OP_DIV,   32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2};
    vecs[8] = '{OP_MULTU, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
    vecs[9] = '{OP_MULT,  32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2};

    reset = 1'b1;
    start = 1'b0;
    op = OP_MULTU;
    rs_val = '0;
    rt_val = '0;
    #1;
    checkOutput("reset/hi_lo", {hi, lo}, 64'd0);
    checkOutput("reset/busy_stall_done", {busy, stall, done}, 3'b000);
    checkOutput("reset/alu_ctl", alu_ctl, ALU_ADD);
    checkOutput("reset/alu_ab", {alu_a, alu_b}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
                    vecs[i].exp_hi, vecs[i].exp_lo, 1'b0);
      waitDone($sformatf("vec%0d", i), 1, 1);
    end

    // A second start during ITER must be ignored.
    applyStimulus("midstart", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'h0000_000F, 1'b0);
    lat = 1;
    st = 1;
    repeat (10) begin
      if (stall) st++;
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b1;
    op = OP_MULTU;
    rs_val = 32'd7;
    rt_val = 32'd7;
    #1;
    checkOutput("midstart/busy", busy, 1);
    if (stall) st++;
    @(posedge clk);
    #1;
    lat++;
    start = 1'b0;
    waitDone("midstart", lat, st);
    extra = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    checkOutput("midstart/extra_done", extra, 0);

    // Hold start high through DONE. DONE must still return to IDLE.
    applyStimulus("held", OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b1);
    waitDone("held", 1, 1);
    checkOutput("held/idle_stall", stall, 1);
    start = 1'b0;

    // Reset asserted while count is 10 aborts the op with no done pulse.
    applyStimulus("abort", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0);
    repeat (21) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b1;
    #1;
    checkOutput("abort/busy_stall_done", {busy, stall, done}, 3'b000);
    checkOutput("abort/hi_lo", {hi, lo}, 64'd0);
    sb.delete();
    model_hi = '0;
    model_lo = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    extra = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    checkOutput("abort/no_done", extra, 0);
    applyStimulus("after_reset", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'h0000_000F, 1'b0);
    waitDone("after_reset", 1, 1);

    // Random ops checked against the behavioural model.
    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : ((i < 2) ? 32'($urandom_range(1, 300)) : $urandom);
      r = model(ro, ra, rb);
      applyStimulus($sformatf("rand%0d", i), ro, ra, rb, r[63:32], r[31:0], 1'b0);
      waitDone($sformatf("rand%0d", i), 1, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
